// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its
// four-phase handshake to the asynchronous instruction register.
package fetch_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRead   = 3'd1,
    StLoad   = 3'd2,
    StDrive  = 3'd3,
    StSpacer = 3'd4
  } fetch_state_e;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned TAG_W     = 2;
  localparam int unsigned PAYLOAD_W = 14;

  localparam logic [TAG_W-1:0]   SPACER_TAG   = 2'b00;
  localparam logic [TAG_W-1:0]   PH_A_DEFAULT = 2'b01;
  localparam logic [TAG_W-1:0]   PH_B_DEFAULT = 2'b10;
  localparam logic [INSTR_W-1:0] SPACER_WORD  = {SPACER_TAG, {PAYLOAD_W{1'b0}}};

  // Alternates between the two data phases; anything unexpected snaps back to ph_a.
  function automatic logic [TAG_W-1:0] next_phase(input logic [TAG_W-1:0] cur,
                                                  input logic [TAG_W-1:0] ph_a,
                                                  input logic [TAG_W-1:0] ph_b);
    return (cur == ph_a) ? ph_b : ph_a;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level, reset to 0.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch stage: reads payloads at pc, tags them with an alternating phase and
// hands them to the asynchronous instruction register with a return-to-zero handshake.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]    PC_RESET    = '0,
  parameter logic [TAG_W-1:0]     PH_A        = PH_A_DEFAULT,
  parameter logic [TAG_W-1:0]     PH_B        = PH_B_DEFAULT,
  parameter int unsigned          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 pc_load,
  input  logic [ADDR_W-1:0]    pc_target,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd,
  input  logic [PAYLOAD_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0]   data,
  input  logic                 ack_next,
  output logic [ADDR_W-1:0]    pc,
  output logic                 busy,
  output logic                 proto_err
);

  fetch_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    target_q, target_d;
  logic                 pending_q, pending_d;
  logic [INSTR_W-1:0]   data_q, data_d;
  logic [TAG_W-1:0]     phase_q, phase_d;
  logic                 proto_err_q, proto_err_d;
  logic                 ack_s;
  logic                 word_done;
  logic                 redirect_now;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_next),
    .q   (ack_s)
  );

  // Handshake sequencing and the data bus
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    phase_d   = phase_q;
    word_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StLoad;
      end
      StLoad: begin
        data_d  = {phase_q, mem_rdata};
        state_d = StDrive;
      end
      StDrive: begin
        if (ack_s) begin
          data_d    = SPACER_WORD;
          phase_d   = next_phase(phase_q, PH_A, PH_B);
          word_done = 1'b1;
          state_d   = StSpacer;
        end
      end
      StSpacer: begin
        if (!ack_s) begin
          state_d = en ? StRead : StIdle;
        end
      end
      default: begin
        data_d  = SPACER_WORD;
        state_d = StIdle;
      end
    endcase
  end

  // Redirects outside a word apply at once; inside a word they wait for its release.
  assign redirect_now = (state_q == StIdle) || (state_q == StSpacer);

  always_comb begin
    pc_d      = pc_q;
    target_d  = target_q;
    pending_d = pending_q;

    if (word_done) begin
      if (pc_load) begin
        pc_d = pc_target;
      end else if (pending_q) begin
        pc_d = target_q;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
      pending_d = 1'b0;
    end else if (pc_load) begin
      if (redirect_now) begin
        pc_d = pc_target;
      end else begin
        pending_d = 1'b1;
        target_d  = pc_target;
      end
    end
  end

  // An ack still high outside DRIVE/SPACER means the downstream never returned to zero.
  always_comb begin
    proto_err_d = proto_err_q;
    if (ack_s && ((state_q == StIdle) || (state_q == StRead) || (state_q == StLoad))) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= PC_RESET;
      target_q    <= '0;
      pending_q   <= 1'b0;
      data_q      <= SPACER_WORD;
      phase_q     <= PH_A;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      pending_q   <= pending_d;
      data_q      <= data_d;
      phase_q     <= phase_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign mem_rd    = (state_q == StRead);
  assign busy      = (state_q != StIdle);
  assign data      = data_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a one-cycle-latency memory model and a
// hand-driven ack line stand in for the instruction memory and downstream register.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [13:0] mem_rdata = '0;
  logic [15:0] data;
  logic        ack_next;
  logic [7:0]  pc;
  logic        busy;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  logic [13:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  instr_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .data      (data),
    .ack_next  (ack_next),
    .pc        (pc),
    .busy      (busy),
    .proto_err (proto_err)
  );

  task automatic wait_data(input bit want_nonzero, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((data !== 16'h0000) == want_nonzero) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_rd === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One complete word: see the tagged data, return ack 3 clk later, see the spacer.
  task automatic run_word(input logic [15:0] exp_data, input logic [7:0] exp_pc,
                          input bit drop_en, input string name);
    bit ok;
    wait_data(1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s data_timeout: data=%h required nonzero", name, data);
      return;
    end
    checks++;
    if (data !== exp_data) begin
      errors++;
      $display("FAIL %s data: got %h required %h", name, data, exp_data);
    end
    if (drop_en) en = 1'b0;
    repeat (3) @(negedge clk);
    ack_next = 1'b1;
    wait_data(1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s spacer_timeout: data=%h required 0000", name, data);
    end
    checks++;
    if (pc !== exp_pc) begin
      errors++;
      $display("FAIL %s pc: got %h required %h", name, pc, exp_pc);
    end
    ack_next = 1'b0;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL %s proto_err: got %b required 0", name, proto_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; pc_load = 1'b0; pc_target = '0; ack_next = 1'b0;
    #1;
    checks++;
    if (data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h required 0000", data); end
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h required 00", pc); end
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b mem_rd=%b proto_err=%b required 0 0 0",
               busy, mem_rd, proto_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_hold: busy=%b required 0", busy); end
  endtask

  task automatic test_single_word();
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL read_cycle: mem_rd=%b mem_addr=%h busy=%b required 1 00 1",
               mem_rd, mem_addr, busy);
    end
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0 || data !== 16'h0000) begin
      errors++;
      $display("FAIL load_cycle: mem_rd=%b data=%h required 0 0000", mem_rd, data);
    end
    @(negedge clk);
    checks++;
    if (data !== 16'h5234) begin
      errors++;
      $display("FAIL latency: data=%h required 5234 two clk after read", data);
    end
    run_word(16'h5234, 8'h01, 1'b0, "word0");
  endtask

  task automatic test_back_to_back();
    bit ok;
    run_word(16'h8001, 8'h02, 1'b0, "word1");
    run_word(16'h6AAA, 8'h03, 1'b1, "word2");
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_idle: busy=%b required 0", busy); end
    checks++;
    if (pc !== 8'h03) begin errors++; $display("FAIL b2b_pc: got %h required 03", pc); end
  endtask

  task automatic test_redirect();
    bit ok;
    @(negedge clk);
    pc_load = 1'b1; pc_target = 8'h05;
    @(negedge clk);
    pc_load = 1'b0;
    checks++;
    if (pc !== 8'h05) begin errors++; $display("FAIL idle_load: pc=%h required 05", pc); end
    en = 1'b1;
    wait_data(1'b1, ok);
    checks++;
    if (!ok || data !== 16'h8555) begin
      errors++;
      $display("FAIL redir_word5: data=%h required 8555", data);
    end
    pc_load = 1'b1; pc_target = 8'h40;
    @(negedge clk);
    pc_load = 1'b0;
    checks++;
    if (data !== 16'h8555 || pc !== 8'h05) begin
      errors++;
      $display("FAIL redir_hold: data=%h pc=%h required 8555 05", data, pc);
    end
    ack_next = 1'b1;
    wait_data(1'b0, ok);
    checks++;
    if (!ok || pc !== 8'h40) begin
      errors++;
      $display("FAIL redir_pc: pc=%h required 40", pc);
    end
    ack_next = 1'b0;
    wait_rd(ok);
    checks++;
    if (!ok || mem_addr !== 8'h40) begin
      errors++;
      $display("FAIL redir_addr: mem_addr=%h required 40", mem_addr);
    end
    wait_data(1'b1, ok);
    checks++;
    if (!ok || data !== 16'h4040) begin
      errors++;
      $display("FAIL redir_word40: data=%h required 4040", data);
    end
    // Two redirects during one word: the later target must be used.
    pc_load = 1'b1; pc_target = 8'h10;
    @(negedge clk);
    pc_target = 8'h20;
    @(negedge clk);
    pc_load = 1'b0;
    en = 1'b0;
    ack_next = 1'b1;
    wait_data(1'b0, ok);
    checks++;
    if (!ok || pc !== 8'h20) begin
      errors++;
      $display("FAIL last_wins: pc=%h required 20", pc);
    end
    ack_next = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_wrap();
    bit ok;
    @(negedge clk);
    pc_load = 1'b1; pc_target = 8'hFF;
    @(negedge clk);
    pc_load = 1'b0;
    checks++;
    if (pc !== 8'hFF) begin errors++; $display("FAIL wrap_load: pc=%h required ff", pc); end
    en = 1'b1;
    run_word(16'hBFFF, 8'h00, 1'b1, "wrap");
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    en = 1'b1;
    wait_data(1'b1, ok);
    checks++;
    if (!ok || data !== 16'h5234) begin
      errors++;
      $display("FAIL mid_word: data=%h required 5234", data);
    end
    rst = 1'b1;
    en  = 1'b0;
    #1;
    checks++;
    if (data !== 16'h0000 || pc !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: data=%h pc=%h busy=%b required 0000 00 0", data, pc, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_proto_err();
    @(negedge clk);
    ack_next = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_set: proto_err=%b required 1", proto_err);
    end
    ack_next = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (proto_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL proto_sticky: proto_err=%b busy=%b required 1 0", proto_err, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_clear: proto_err=%b required 0", proto_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = 14'h1234;
    mem[8'h01] = 14'h0001;
    mem[8'h02] = 14'h2AAA;
    mem[8'h05] = 14'h0555;
    mem[8'h40] = 14'h0040;
    mem[8'hFF] = 14'h3FFF;

    test_reset();
    test_single_word();
    test_back_to_back();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_proto_err();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
